// File: rtl/oserdes_tx_pkg.sv
// Shared types and helpers for the OSERDES transmit feeder.
// State encoding, default pattern words and serial bit-order mapping.
package oserdes_tx_pkg;

    typedef enum logic [1:0] {
        WAKE,
        TRAIN,
        RUN
    } state_t;

    localparam logic [7:0] DEF_TRAIN_WORD = 8'h0F;
    localparam logic [7:0] DEF_IDLE_WORD  = 8'h00;

    // d[0] is the first serial bit; msb_first puts byte bit 7 there.
    function automatic logic [7:0] bitmap(input logic [7:0] b, input bit msb_first);
        logic [7:0] r;
        r = b;
        if (msb_first) begin
            for (int i = 0; i < 8; i++) begin
                r[i] = b[7-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/oserdes_tx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible on head the cycle after it is written.
// Backpressure: pushes when full and pops when empty are dropped internally.
module oserdes_tx_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/oserdes_tx_feeder.sv
// Byte-stream to 8:1 OSERDES parallel-word feeder with wake delay and training bursts.
// Latency: byte accepted into an empty FIFO in RUN appears on d one edge later.
// Backpressure: s_ready drops only when the FIFO is full or rst is high.
module oserdes_tx_feeder
    import oserdes_tx_pkg::*;
#(
    parameter int         FIFO_AW    = 4,
    parameter int         OCE_DELAY  = 2,
    parameter int         TRAIN_LEN  = 16,
    parameter logic [7:0] TRAIN_WORD = DEF_TRAIN_WORD,
    parameter logic [7:0] IDLE_WORD  = DEF_IDLE_WORD,
    parameter bit         MSB_FIRST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             train_req,
    output logic [7:0]       d,
    output logic             oce,
    output logic             link_ready,
    output logic [FIFO_AW:0] fifo_level
);

    localparam int CNT_MAX = (TRAIN_LEN > OCE_DELAY) ? TRAIN_LEN : OCE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;
    logic [7:0]       head;
    logic             full;
    logic             empty;
    logic             last_train;
    logic             wake_done;
    logic [7:0]       run_word;

    assign s_ready    = !rst && !full;
    assign push       = s_valid && s_ready;
    assign last_train = (cnt == CNT_W'(TRAIN_LEN - 1));
    assign wake_done  = (cnt == CNT_W'(OCE_DELAY - 1));
    assign run_word   = empty ? IDLE_WORD : bitmap(head, MSB_FIRST);

    // A train_req in RUN suppresses the pop so the head byte waits out the burst.
    assign pop = !empty && (((state == RUN) && !train_req) ||
                            ((state == TRAIN) && last_train));

    oserdes_tx_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .head  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAKE;
            cnt        <= '0;
            d          <= IDLE_WORD;
            oce        <= 1'b0;
            link_ready <= 1'b0;
        end else begin
            case (state)
                WAKE: begin
                    if (wake_done) begin
                        state <= TRAIN;
                        cnt   <= '0;
                        oce   <= 1'b1;
                        d     <= TRAIN_WORD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        d   <= IDLE_WORD;
                    end
                end
                TRAIN: begin
                    if (last_train) begin
                        state      <= RUN;
                        link_ready <= 1'b1;
                        d          <= run_word;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        d   <= TRAIN_WORD;
                    end
                end
                RUN: begin
                    if (train_req) begin
                        state      <= TRAIN;
                        cnt        <= '0;
                        link_ready <= 1'b0;
                        d          <= TRAIN_WORD;
                    end else begin
                        d <= run_word;
                    end
                end
                default: begin
                    state <= WAKE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oserdes_tx_feeder.sv
// Bench for oserdes_tx_feeder: LSB-first and MSB-first instances share one stimulus.
module tb_oserdes_tx_feeder;

    localparam int DEPTH = 16;
    localparam int TLEN  = 16;
    localparam int ODLY  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       train_req = 1'b0;
    logic [7:0] s_data = 8'h00;

    logic       s_ready, oce, link_ready;
    logic [7:0] d;
    logic [4:0] fifo_level;
    logic       s_ready_r, oce_r, link_ready_r;
    logic [7:0] d_r;
    logic [4:0] fifo_level_r;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oserdes_tx_feeder #(.MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .train_req(train_req), .d(d), .oce(oce), .link_ready(link_ready), .fifo_level(fifo_level)
    );

    oserdes_tx_feeder #(.MSB_FIRST(1'b1)) dut_r (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_r),
        .train_req(train_req), .d(d_r), .oce(oce_r), .link_ready(link_ready_r), .fifo_level(fifo_level_r)
    );

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Reference: wake countdown, training words remaining, and a byte queue.
    logic [7:0] q[$];
    logic [7:0] e_d = 8'h00;
    logic       e_dat = 1'b0;
    logic       e_oce = 1'b0;
    logic       e_lr = 1'b0;
    int         wake_left = ODLY;
    int         train_left = 0;

    always @(posedge clk) begin : model
        logic acc;
        logic was_run;
        if (rst) begin
            q.delete();
            e_d = 8'h00; e_dat = 1'b0; e_oce = 1'b0; e_lr = 1'b0;
            wake_left = ODLY; train_left = 0;
        end else begin
            acc = s_valid && (q.size() < DEPTH);
            was_run = e_lr;
            e_dat = 1'b0;
            if (wake_left > 0) begin
                wake_left--;
                if (wake_left == 0) train_left = TLEN;
            end
            if (wake_left > 0) begin
                e_d = 8'h00; e_oce = 1'b0; e_lr = 1'b0;
            end else begin
                e_oce = 1'b1;
                if (train_left == 0 && was_run && train_req) train_left = TLEN;
                if (train_left > 0) begin
                    train_left--;
                    e_d = 8'h0F; e_lr = 1'b0;
                end else begin
                    e_lr = 1'b1;
                    if (q.size() > 0) begin
                        e_d = q.pop_front();
                        e_dat = 1'b1;
                    end else begin
                        e_d = 8'h00;
                    end
                end
            end
            if (acc) q.push_back(s_data);
        end
    end

    task automatic test_reset();
        logic [7:0] wd;
        logic       wo, wl;
        rst = 1'b1; s_valid = 1'b0; train_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (d !== 8'h00 || oce !== 1'b0 || link_ready !== 1'b0 || fifo_level !== 5'd0 || s_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_state: d=%h oce=%b lr=%b lvl=%0d rdy=%b, want 00/0/0/0/0", d, oce, link_ready, fifo_level, s_ready);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            // train_req pulses in WAKE, mid-burst and on the last burst cycle must be ignored
            train_req = (i == 0 || i == 8 || i == 16) ? 1'b1 : 1'b0;
            @(negedge clk);
            wo = (i >= 1);
            wl = (i >= 17);
            wd = (i >= 1 && i <= 16) ? 8'h0F : 8'h00;
            checks++;
            if (d !== wd || d_r !== wd || oce !== wo || link_ready !== wl) begin
                failures++;
                $display("FAIL wake_train cyc=%0d: d=%h d_r=%h oce=%b lr=%b, want d=%h oce=%b lr=%b", i, d, d_r, oce, link_ready, wd, wo, wl);
            end
        end
        train_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        logic [7:0] wd, wr;
        logic [4:0] wlvl;
        b[0] = 8'h0F; b[1] = 8'h05; b[2] = 8'h06; b[3] = 8'h0F;
        for (int j = 0; j < 7; j++) begin
            s_valid = (j < 4);
            s_data  = (j < 4) ? b[j] : 8'h00;
            @(negedge clk);
            if (j >= 1 && j <= 4) begin
                wd = b[j-1];
                wr = rev8(b[j-1]);
            end else begin
                wd = 8'h00;
                wr = 8'h00;
            end
            wlvl = (j < 4) ? 5'd1 : 5'd0;
            checks++;
            if (d !== wd || d_r !== wr || fifo_level !== wlvl || link_ready !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d: d=%h d_r=%h lvl=%0d lr=%b, want d=%h d_r=%h lvl=%0d lr=1", j, d, d_r, fifo_level, link_ready, wd, wr, wlvl);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_train_req();
        logic [7:0] b [6];
        logic [7:0] wd;
        logic       wl, wdat;
        for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
        for (int j = 0; j < 25; j++) begin
            s_valid   = (j < 6);
            s_data    = (j < 6) ? b[j] : 8'h00;
            train_req = (j == 3 || j == 10);
            @(negedge clk);
            wdat = 1'b0;
            if (j == 0) wd = 8'h00;
            else if (j <= 2) begin wd = b[j-1]; wdat = 1'b1; end
            else if (j <= 18) wd = 8'h0F;
            else if (j <= 22) begin wd = b[j-17]; wdat = 1'b1; end
            else wd = 8'h00;
            wl = !(j >= 3 && j <= 18);
            checks++;
            if (d !== wd || d_r !== (wdat ? rev8(wd) : wd) || link_ready !== wl) begin
                failures++;
                $display("FAIL train_req cyc=%0d: d=%h d_r=%h lr=%b, want d=%h lr=%b", j, d, d_r, link_ready, wd, wl);
            end
        end
        s_valid = 1'b0; train_req = 1'b0;
    endtask

    task automatic test_msb();
        logic [7:0] wd, wr;
        for (int j = 0; j < 4; j++) begin
            s_valid = (j < 2);
            s_data  = (j == 0) ? 8'h01 : 8'h0E;
            @(negedge clk);
            wd = (j == 1) ? 8'h01 : (j == 2) ? 8'h0E : 8'h00;
            wr = (j == 1) ? 8'h80 : (j == 2) ? 8'h70 : 8'h00;
            checks++;
            if (d !== wd || d_r !== wr) begin
                failures++;
                $display("FAIL msb_first cyc=%0d: d=%h d_r=%h, want d=%h d_r=%h", j, d, d_r, wd, wr);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_fill();
        logic       pend, lr_before, drained;
        int         n_pre;
        logic [7:0] want;
        n_pre = 0;
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h10; train_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 58; i++) begin
            #1;
            pend = s_ready;
            lr_before = link_ready;
            @(negedge clk);
            if (pend) begin
                s_data = s_data + 8'd1;
                if (!lr_before) n_pre++;
            end
            if (i == 16) begin
                checks++;
                if (fifo_level !== 5'd16 || s_ready !== 1'b0 || n_pre != 16) begin
                    failures++;
                    $display("FAIL fill_full: lvl=%0d rdy=%b accepted=%0d, want 16/0/16", fifo_level, s_ready, n_pre);
                end
            end
            if (i >= 17) begin
                want = 8'h10 + 8'(i - 17);
                checks++;
                if (d !== want || link_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL fill_drain cyc=%0d: d=%h lr=%b, want d=%h lr=1", i, d, link_ready, want);
                end
            end
        end
        s_valid = 1'b0;
        drained = 1'b0;
        for (int k = 0; k < 40 && !drained; k++) begin
            @(negedge clk);
            if (fifo_level == 5'd0 && d == 8'h00) drained = 1'b1;
        end
        checks++;
        if (!drained) begin
            failures++;
            $display("FAIL fill_drain_timeout: lvl=%0d d=%h, want 0/00 within 40 cycles", fifo_level, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] wd;
        train_req = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        train_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom_range(1, 255));
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (fifo_level !== 5'd8 || d !== 8'h0F) begin
            failures++;
            $display("FAIL mid_queued: lvl=%0d d=%h, want 8/0f", fifo_level, d);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd0 || oce !== 1'b0 || d !== 8'h00 || link_ready !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: lvl=%0d oce=%b d=%h lr=%b rdy=%b, want 0/0/00/0/0", fifo_level, oce, d, link_ready, s_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            wd = (i >= 1 && i <= 16) ? 8'h0F : 8'h00;
            checks++;
            if (d !== wd || fifo_level !== 5'd0) begin
                failures++;
                $display("FAIL mid_restart cyc=%0d: d=%h lvl=%0d, want d=%h lvl=0", i, d, fifo_level, wd);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] wr;
        logic       wrdy;
        int         bias;
        rst = 1'b1; s_valid = 1'b0; train_req = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            bias      = ((n / 200) % 2 == 1) ? 95 : 40;
            rst       = ($urandom_range(0, 999) < 3);
            s_valid   = ($urandom_range(0, 99) < bias);
            s_data    = 8'($urandom);
            train_req = ($urandom_range(0, 99) < 3);
            @(negedge clk);
            wr   = e_dat ? rev8(e_d) : e_d;
            wrdy = !rst && (q.size() < DEPTH);
            checks++;
            if (d !== e_d || d_r !== wr || oce !== e_oce || link_ready !== e_lr ||
                fifo_level !== 5'(q.size()) || s_ready !== wrdy) begin
                failures++;
                $display("FAIL random cyc=%0d: d=%h d_r=%h oce=%b lr=%b lvl=%0d rdy=%b, want d=%h d_r=%h oce=%b lr=%b lvl=%0d rdy=%b",
                         n, d, d_r, oce, link_ready, fifo_level, s_ready, e_d, wr, e_oce, e_lr, q.size(), wrdy);
            end
        end
        rst = 1'b0; s_valid = 1'b0; train_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_train_req();
        test_msb();
        test_fill();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
